// File: rtl/idecode.sv
// rtl/idecode.sv - MIPS instruction-decode stage: register file, control decode, ID/EX latch
module idecode (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IF_ID_instr,
   input  logic [31:0] IF_ID_npc,
   input  logic        EX_MEM_PCSrc,
   input  logic        MEM_WB_RegWrite,
   input  logic [4:0]  MEM_WB_Writereg,
   input  logic [31:0] WB_mux5_writedata,
   output logic [1:0]  ID_EX_wb_ctlout,
   output logic [2:0]  ID_EX_m_ctlout,
   output logic [3:0]  ID_EX_ex_ctlout,
   output logic [31:0] ID_EX_npc,
   output logic [31:0] ID_EX_readdat1,
   output logic [31:0] ID_EX_readdat2,
   output logic [31:0] ID_EX_sign_ext,
   output logic [4:0]  ID_EX_instr_2016,
   output logic [4:0]  ID_EX_instr_1511
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;

   assign opcode = IF_ID_instr[31:26];
   assign rs     = IF_ID_instr[25:21];
   assign rt     = IF_ID_instr[20:16];
   assign rd     = IF_ID_instr[15:11];
   assign imm    = IF_ID_instr[15:0];

   logic [31:0] regs_q [0:31];
   logic        wr_en;

   // r0 is hard-wired to zero, so a write aimed at it is treated as no write at all
   assign wr_en = MEM_WB_RegWrite && (MEM_WB_Writereg != 5'd0);

   // Register file write port; reset wipes every entry and drops any pending write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[MEM_WB_Writereg] <= WB_mux5_writedata;
      end
   end

   logic [31:0] rdat1_d;
   logic [31:0] rdat2_d;

   // Read ports with write-through so a same-cycle WB write is visible to decode
   always_comb begin
      rdat1_d = '0;
      rdat2_d = '0;
      if (rs != 5'd0) begin
         rdat1_d = (wr_en && (MEM_WB_Writereg == rs)) ? WB_mux5_writedata : regs_q[rs];
      end
      if (rt != 5'd0) begin
         rdat2_d = (wr_en && (MEM_WB_Writereg == rt)) ? WB_mux5_writedata : regs_q[rt];
      end
   end

   logic [1:0] wb_d;
   logic [2:0] m_d;
   logic [3:0] ex_d;

   // Opcode to control groups; a taken branch squashes the controls but not the data
   always_comb begin
      wb_d = 2'b00;
      m_d  = 3'b000;
      ex_d = 4'b0000;
      case (opcode)
         OP_RTYPE: begin wb_d = 2'b10; m_d = 3'b000; ex_d = 4'b1100; end
         OP_LW:    begin wb_d = 2'b11; m_d = 3'b010; ex_d = 4'b0001; end
         OP_SW:    begin wb_d = 2'b00; m_d = 3'b001; ex_d = 4'b0001; end
         OP_BEQ:   begin wb_d = 2'b00; m_d = 3'b100; ex_d = 4'b0010; end
         default:  begin wb_d = 2'b00; m_d = 3'b000; ex_d = 4'b0000; end
      endcase
      if (EX_MEM_PCSrc) begin
         wb_d = 2'b00;
         m_d  = 3'b000;
         ex_d = 4'b0000;
      end
   end

   logic [31:0] sext_d;
   assign sext_d = {{16{imm[15]}}, imm};

   logic [1:0]  wb_q;
   logic [2:0]  m_q;
   logic [3:0]  ex_q;
   logic [31:0] npc_q;
   logic [31:0] rdat1_q;
   logic [31:0] rdat2_q;
   logic [31:0] sext_q;
   logic [4:0]  rt_q;
   logic [4:0]  rd_q;

   // ID/EX pipeline latch; no stall, so it loads every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q    <= '0;
         m_q     <= '0;
         ex_q    <= '0;
         npc_q   <= '0;
         rdat1_q <= '0;
         rdat2_q <= '0;
         sext_q  <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
      end else begin
         wb_q    <= wb_d;
         m_q     <= m_d;
         ex_q    <= ex_d;
         npc_q   <= IF_ID_npc;
         rdat1_q <= rdat1_d;
         rdat2_q <= rdat2_d;
         sext_q  <= sext_d;
         rt_q    <= rt;
         rd_q    <= rd;
      end
   end

   assign ID_EX_wb_ctlout  = wb_q;
   assign ID_EX_m_ctlout   = m_q;
   assign ID_EX_ex_ctlout  = ex_q;
   assign ID_EX_npc        = npc_q;
   assign ID_EX_readdat1   = rdat1_q;
   assign ID_EX_readdat2   = rdat2_q;
   assign ID_EX_sign_ext   = sext_q;
   assign ID_EX_instr_2016 = rt_q;
   assign ID_EX_instr_1511 = rd_q;

endmodule

// File: tb/tb_idecode.sv
// tb/tb_idecode.sv - directed self-checking bench for idecode
module tb_idecode;

   logic        clk;
   logic        rst;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_npc;
   logic        EX_MEM_PCSrc;
   logic        MEM_WB_RegWrite;
   logic [4:0]  MEM_WB_Writereg;
   logic [31:0] WB_mux5_writedata;
   logic [1:0]  ID_EX_wb_ctlout;
   logic [2:0]  ID_EX_m_ctlout;
   logic [3:0]  ID_EX_ex_ctlout;
   logic [31:0] ID_EX_npc;
   logic [31:0] ID_EX_readdat1;
   logic [31:0] ID_EX_readdat2;
   logic [31:0] ID_EX_sign_ext;
   logic [4:0]  ID_EX_instr_2016;
   logic [4:0]  ID_EX_instr_1511;

   int checks = 0;
   int errors = 0;

   idecode dut (
      .clk               (clk),
      .rst               (rst),
      .IF_ID_instr       (IF_ID_instr),
      .IF_ID_npc         (IF_ID_npc),
      .EX_MEM_PCSrc      (EX_MEM_PCSrc),
      .MEM_WB_RegWrite   (MEM_WB_RegWrite),
      .MEM_WB_Writereg   (MEM_WB_Writereg),
      .WB_mux5_writedata (WB_mux5_writedata),
      .ID_EX_wb_ctlout   (ID_EX_wb_ctlout),
      .ID_EX_m_ctlout    (ID_EX_m_ctlout),
      .ID_EX_ex_ctlout   (ID_EX_ex_ctlout),
      .ID_EX_npc         (ID_EX_npc),
      .ID_EX_readdat1    (ID_EX_readdat1),
      .ID_EX_readdat2    (ID_EX_readdat2),
      .ID_EX_sign_ext    (ID_EX_sign_ext),
      .ID_EX_instr_2016  (ID_EX_instr_2016),
      .ID_EX_instr_1511  (ID_EX_instr_1511)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex);
      chk({tag, ".wb"}, {30'd0, ID_EX_wb_ctlout}, {30'd0, wb});
      chk({tag, ".m"},  {29'd0, ID_EX_m_ctlout},  {29'd0, m});
      chk({tag, ".ex"}, {28'd0, ID_EX_ex_ctlout}, {28'd0, ex});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      IF_ID_instr = 32'h0;
      IF_ID_npc = 32'h0;
      EX_MEM_PCSrc = 1'b0;
      MEM_WB_RegWrite = 1'b0;
      MEM_WB_Writereg = 5'd0;
      WB_mux5_writedata = 32'h0;

      // reset held across edges
      IF_ID_instr = 32'h8D09FFFC;
      IF_ID_npc = 32'h44;
      step();
      step();
      chk_ctl("rst_hold", 2'b00, 3'b000, 4'b0000);
      chk("rst_hold.npc", ID_EX_npc, 32'h0);
      chk("rst_hold.sext", ID_EX_sign_ext, 32'h0);

      // first edge after release decodes R-type 0x00000000
      rst = 1'b0;
      IF_ID_instr = 32'h00000000;
      IF_ID_npc = 32'h4;
      step();
      chk_ctl("rtype0", 2'b10, 3'b000, 4'b1100);
      chk("rtype0.rd1", ID_EX_readdat1, 32'h0);
      chk("rtype0.rd2", ID_EX_readdat2, 32'h0);
      chk("rtype0.npc", ID_EX_npc, 32'h4);

      // write r8, then decode add r10,r8,r9
      MEM_WB_RegWrite = 1'b1;
      MEM_WB_Writereg = 5'd8;
      WB_mux5_writedata = 32'hDEADBEEF;
      step();
      MEM_WB_RegWrite = 1'b0;
      IF_ID_instr = 32'h01095020;
      IF_ID_npc = 32'h8;
      step();
      chk("add.rd1", ID_EX_readdat1, 32'hDEADBEEF);
      chk("add.rd2", ID_EX_readdat2, 32'h0);
      chk("add.rd", {27'd0, ID_EX_instr_1511}, 32'd10);
      chk("add.rt", {27'd0, ID_EX_instr_2016}, 32'd9);
      chk_ctl("add", 2'b10, 3'b000, 4'b1100);

      // same-cycle write-through on both ports
      MEM_WB_RegWrite = 1'b1;
      MEM_WB_Writereg = 5'd9;
      WB_mux5_writedata = 32'h12345678;
      IF_ID_instr = 32'h01295020;
      step();
      chk("byp.rd1", ID_EX_readdat1, 32'h12345678);
      chk("byp.rd2", ID_EX_readdat2, 32'h12345678);
      MEM_WB_RegWrite = 1'b0;
      WB_mux5_writedata = 32'h0;
      step();
      chk("byp_commit.rd1", ID_EX_readdat1, 32'h12345678);

      // lw / sw / beq
      IF_ID_instr = 32'h8D09FFFC;
      step();
      chk_ctl("lw", 2'b11, 3'b010, 4'b0001);
      chk("lw.sext", ID_EX_sign_ext, 32'hFFFFFFFC);
      chk("lw.rd1", ID_EX_readdat1, 32'hDEADBEEF);
      IF_ID_instr = 32'hAD090004;
      step();
      chk_ctl("sw", 2'b00, 3'b001, 4'b0001);
      chk("sw.sext", ID_EX_sign_ext, 32'h00000004);
      IF_ID_instr = 32'h1109FFFF;
      step();
      chk_ctl("beq", 2'b00, 3'b100, 4'b0010);
      chk("beq.sext", ID_EX_sign_ext, 32'hFFFFFFFF);

      // r0 protection, during and after the write
      MEM_WB_RegWrite = 1'b1;
      MEM_WB_Writereg = 5'd0;
      WB_mux5_writedata = 32'hFFFFFFFF;
      IF_ID_instr = 32'h00000000;
      step();
      chk("r0_during.rd1", ID_EX_readdat1, 32'h0);
      chk("r0_during.rd2", ID_EX_readdat2, 32'h0);
      MEM_WB_RegWrite = 1'b0;
      step();
      chk("r0_after.rd1", ID_EX_readdat1, 32'h0);

      // flush of lw: controls zero, data still latched
      EX_MEM_PCSrc = 1'b1;
      IF_ID_instr = 32'h8D09FFFC;
      IF_ID_npc = 32'h100;
      step();
      chk_ctl("flush", 2'b00, 3'b000, 4'b0000);
      chk("flush.npc", ID_EX_npc, 32'h100);
      chk("flush.sext", ID_EX_sign_ext, 32'hFFFFFFFC);
      chk("flush.rd1", ID_EX_readdat1, 32'hDEADBEEF);

      // flush with write-back: write still commits
      MEM_WB_RegWrite = 1'b1;
      MEM_WB_Writereg = 5'd10;
      WB_mux5_writedata = 32'hCAFEF00D;
      IF_ID_instr = 32'h01095020;
      step();
      chk_ctl("flush_wb", 2'b00, 3'b000, 4'b0000);
      EX_MEM_PCSrc = 1'b0;
      MEM_WB_RegWrite = 1'b0;
      IF_ID_instr = 32'h014A5820;
      step();
      chk("flush_wb.rd1", ID_EX_readdat1, 32'hCAFEF00D);
      chk("flush_wb.rd2", ID_EX_readdat2, 32'hCAFEF00D);
      chk_ctl("rtype_after_flush", 2'b10, 3'b000, 4'b1100);

      // unknown opcode 6'h3F
      IF_ID_instr = 32'hFC000000;
      step();
      chk_ctl("op3f", 2'b00, 3'b000, 4'b0000);
      chk("op3f.sext", ID_EX_sign_ext, 32'h0);

      // async reset mid-cycle, with an in-flight write discarded
      IF_ID_instr = 32'h8D09FFFC;
      IF_ID_npc = 32'h200;
      step();
      chk_ctl("pre_rst", 2'b11, 3'b010, 4'b0001);
      MEM_WB_RegWrite = 1'b1;
      MEM_WB_Writereg = 5'd12;
      WB_mux5_writedata = 32'h00000001;
      #2;
      rst = 1'b1;
      #1;
      chk_ctl("async_rst", 2'b00, 3'b000, 4'b0000);
      chk("async_rst.npc", ID_EX_npc, 32'h0);
      chk("async_rst.rd1", ID_EX_readdat1, 32'h0);
      step();
      chk("rst_edge.npc", ID_EX_npc, 32'h0);
      rst = 1'b0;
      MEM_WB_RegWrite = 1'b0;
      IF_ID_instr = 32'h010C0000;
      IF_ID_npc = 32'h300;
      step();
      chk("post_rst.rd1", ID_EX_readdat1, 32'h0);
      chk("post_rst.rd2", ID_EX_readdat2, 32'h0);
      chk("post_rst.npc", ID_EX_npc, 32'h300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/idecode.md
# idecode

Instruction-decode stage of the five-stage MIPS pipeline. It sits directly downstream of the fetch stage and consumes the `IF_ID_instr` / `IF_ID_npc` pair that fetch produces. It holds the 32×32 register file, decodes the opcode into WB/M/EX control groups, and sign-extends the immediate. All results are registered into the ID/EX pipeline latch for the execute stage.

## Interface
Parameters: none.

- `clk` input 1 — single clock; all state updates on rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `IF_ID_instr` input 32 — instruction from fetch.
- `IF_ID_npc` input 32 — PC+4 from fetch.
- `EX_MEM_PCSrc` input 1 — taken branch; flushes the instruction being decoded.
- `MEM_WB_RegWrite` input 1 — write-back enable.
- `MEM_WB_Writereg` input 5 — write-back destination register.
- `WB_mux5_writedata` input 32 — write-back data.
- `ID_EX_wb_ctlout` output 2 — {RegWrite, MemtoReg}.
- `ID_EX_m_ctlout` output 3 — {Branch, MemRead, MemWrite}.
- `ID_EX_ex_ctlout` output 4 — {RegDst, ALUOp[1:0], ALUSrc}.
- `ID_EX_npc` output 32 — latched `IF_ID_npc`.
- `ID_EX_readdat1` output 32 — rs value.
- `ID_EX_readdat2` output 32 — rt value.
- `ID_EX_sign_ext` output 32 — sign-extended instr[15:0].
- `ID_EX_instr_2016` output 5 — instr[20:16] (rt).
- `ID_EX_instr_1511` output 5 — instr[15:11] (rd).

## Operation
- Field split: opcode = instr[31:26]; rs = [25:21]; rt = [20:16]; rd = [15:11]; imm = [15:0].
- Control decode (wb / m / ex):
  - R-type 6'h00: 10 / 000 / 1100.
  - lw 6'h23: 11 / 010 / 0001.
  - sw 6'h2B: 00 / 001 / 0001.
  - beq 6'h04: 00 / 100 / 0010.
  - Any other opcode: all zero (NOP).
- Register file:
  - 32 entries × 32 bits.
  - Register 0 always reads 0; writes to register 0 are discarded.
  - Write occurs on the rising edge when `MEM_WB_RegWrite`=1 and `MEM_WB_Writereg`≠0.
- Write-through bypass: when `MEM_WB_RegWrite`=1, `MEM_WB_Writereg`≠0 and it equals rs (or rt), the combinational read returns `WB_mux5_writedata` in the same cycle. This resolves the WB→ID same-cycle hazard.
- Sign extension: {{16{imm[15]}}, imm}.
- Flush: when `EX_MEM_PCSrc`=1 at the edge, the three control fields latch as zero. The data fields latch normally.
- No stall input; the latch updates every cycle.

## Timing
- Latency: 1 cycle. Inputs present before edge N appear on the ID_EX outputs after edge N.
- Register-file read is combinational from `IF_ID_instr` plus the bypass. The write is committed at the same edge.
- Reset (asynchronous, immediate on `rst`=1, independent of `clk`):
  - All ID_EX outputs go to 0.
  - All 32 registers are cleared to 0.
  - Reset held across edges keeps everything at 0.
  - Reset asserted mid-operation discards any in-flight write.
- First edge after reset deassertion latches the current inputs normally.
- Simultaneous events:
  - Flush and write-back in the same cycle: the write still commits; only the control fields are zeroed.
  - Write to r0 together with a read of r0: the read returns 0; no bypass.
  - Both rs and rt equal the write register: both bypass.

## Test plan
- Reset: assert `rst` asynchronously between edges → all outputs read 0 immediately. After release, decoding instr 0x00000000 gives wb=00, m=000, ex=1100, readdat1=readdat2=0.
- Write then read:
  - Cycle 1: write r8=0xDEADBEEF.
  - Cycle 2: decode `add` 0x01095020 (rs=8, rt=9, rd=10).
  - Expected: readdat1=0xDEADBEEF, readdat2=0, instr_1511=10, ex=1100, wb=10.
- Bypass: in the same cycle, write r9=0x12345678 and decode 0x01295020 (rs=rt=9) → readdat1=readdat2=0x12345678 after that edge.
- lw / sw / beq with negative immediate:
  - 0x8D09FFFC → wb=11, m=010, ex=0001, sign_ext=0xFFFFFFFC.
  - 0xAD090004 → wb=00, m=001, ex=0001, sign_ext=0x00000004.
  - 0x1109FFFF → m=100, ex=0010, sign_ext=0xFFFFFFFF.
- r0 protection: write r0=0xFFFFFFFF, then decode rs=0 → readdat1=0, both during the write cycle and after it.
- Flush and unknown opcode:
  - lw with `EX_MEM_PCSrc`=1 → wb=m=ex=0, npc and sign_ext still latched.
  - Opcode 6'h3F → all controls 0.
